// File: rtl/ones_count_seq.sv
// ones_count_seq: drives an attached shift register (load, then WIDTH right
// shifts) and accumulates its serial LSB to report the word's population count.
module ones_count_seq #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CW    = 4
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic          i_bit,
   output logic [1:0]    o_sel,
   output logic          o_busy,
   output logic          o_done,
   output logic [CW-1:0] o_count
);

   localparam int unsigned BCW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

   localparam logic [1:0] SEL_HOLD  = 2'b00;
   localparam logic [1:0] SEL_SHR   = 2'b10;
   localparam logic [1:0] SEL_LOAD  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_acc;
   logic [BCW-1:0]   r_bitcnt;
   logic [CW-1:0]    r_count;
   logic [1:0]       r_sel;
   logic             r_busy;
   logic             r_done;
   logic [CW-1:0]    w_acc_sum;

   assign w_acc_sum = r_acc + CW'(i_bit);

   assign o_sel   = r_sel;
   assign o_busy  = r_busy;
   assign o_done  = r_done;
   assign o_count = r_count;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; start requests outside IDLE/DONE are dropped
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_state_nxt = S_LOAD;
         S_LOAD:  w_state_nxt = S_SHIFT;
         S_SHIFT: if (r_bitcnt == '0) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = i_start ? S_LOAD : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Registered output decode of the state being entered
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sel  <= SEL_HOLD;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_sel  <= SEL_HOLD;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         case (w_state_nxt)
            S_LOAD: begin
               r_sel  <= SEL_LOAD;
               r_busy <= 1'b1;
            end
            S_SHIFT: begin
               r_sel  <= SEL_SHR;
               r_busy <= 1'b1;
            end
            S_DONE:  r_done <= 1'b1;
            default: r_sel  <= SEL_HOLD;
         endcase
      end
   end

   // Accumulator, bit counter and result; result only moves on DONE entry
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_acc    <= '0;
         r_bitcnt <= '0;
         r_count  <= '0;
      end else begin
         case (r_state)
            S_LOAD: begin
               r_acc    <= '0;
               r_bitcnt <= LAST_BIT;
            end
            S_SHIFT: begin
               r_acc    <= w_acc_sum;
               r_bitcnt <= r_bitcnt - BCW'(1);
               if (r_bitcnt == '0) r_count <= w_acc_sum;
            end
            default: begin
               r_acc    <= r_acc;
               r_bitcnt <= r_bitcnt;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ones_count_seq.sv
// Bench for ones_count_seq: behavioural 8-bit shift register beside the DUT,
// directed scenarios plus a full 256-word popcount sweep.
module tb_ones_count_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic       sbit;
   logic [1:0] sel;
   logic       busy;
   logic       done;
   logic [3:0] count;
   logic [7:0] par;
   logic [7:0] sr;

   int errors;
   int checks;
   int done_cnt;
   int load_cnt;
   int sel01_cnt;

   ones_count_seq #(.WIDTH(8), .CW(4)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (start),
      .i_bit   (sbit),
      .o_sel   (sel),
      .o_busy  (busy),
      .o_done  (done),
      .o_count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Attached shift register; serial input tied high so extra shifts would show
   initial sr = 8'h00;
   always @(posedge clk) begin
      case (sel)
         2'b11:   sr <= par;
         2'b10:   sr <= {1'b1, sr[7:1]};
         2'b01:   sr <= {sr[6:0], 1'b1};
         default: sr <= sr;
      endcase
   end
   assign sbit = sr[0];

   // Event counters sampled mid-cycle
   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (sel === 2'b11) load_cnt++;
      if (sel === 2'b01) sel01_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] popcnt(input logic [7:0] w);
      logic [3:0] n;
      n = 4'd0;
      for (int b = 0; b < 8; b++) n = n + 4'(w[b]);
      return n;
   endfunction

   task automatic test_reset();
      rst = 1'b1; start = 1'b0;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if (sel !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || count !== 4'd0) begin
         errors++;
         $display("FAIL reset: sel=%b busy=%b done=%b count=%0d, want 00/0/0/0", sel, busy, done, count);
      end
   endtask

   task automatic test_idle();
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (sel !== 2'b00 || done !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL idle[%0d]: sel=%b done=%b count=%0d, want 00/0/0", i, sel, done, count);
         end
      end
   endtask

   task automatic test_single_a5();
      par = 8'hA5; start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (sel !== 2'b11 || busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL a5_load: sel=%b busy=%b done=%b, want 11/1/0", sel, busy, done);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (sel !== 2'b10 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL a5_shift[%0d]: sel=%b busy=%b done=%b, want 10/1/0", i, sel, busy, done);
         end
      end
      tick();
      checks++;
      if (done !== 1'b1 || count !== 4'd4 || sel !== 2'b00 || busy !== 1'b0) begin
         errors++;
         $display("FAIL a5_done: done=%b count=%0d sel=%b busy=%b, want 1/4/00/0", done, count, sel, busy);
      end
      tick();
      checks++;
      if (done !== 1'b0 || count !== 4'd4 || sel !== 2'b00) begin
         errors++;
         $display("FAIL a5_after: done=%b count=%0d sel=%b, want 0/4/00", done, count, sel);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] words [4];
      logic [3:0] exp   [4];
      words = '{8'h00, 8'hFF, 8'h01, 8'h80};
      exp   = '{4'd0, 4'd8, 4'd1, 4'd1};
      start = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
         par = words[k];
         checks++;
         if (sel !== 2'b11) begin
            errors++;
            $display("FAIL b2b_load[%0d]: sel=%b, want 11", k, sel);
         end
         for (int i = 0; i < 8; i++) tick();
         checks++;
         if (sel !== 2'b10 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_shift[%0d]: sel=%b done=%b, want 10/0", k, sel, done);
         end
         tick();
         checks++;
         if (done !== 1'b1 || count !== exp[k]) begin
            errors++;
            $display("FAIL b2b_done[%0d]: done=%b count=%0d, want 1/%0d", k, done, count, exp[k]);
         end
         if (k == 3) start = 1'b0;
         tick();
      end
      checks++;
      if (sel !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: sel=%b busy=%b done=%b, want 00/0/0", sel, busy, done);
      end
   endtask

   task automatic test_ignore_start();
      int d0, l0;
      d0 = done_cnt; l0 = load_cnt;
      par = 8'h3C; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      start = 1'b1;
      tick(); tick(); tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (done !== 1'b1 || count !== 4'd4) begin
         errors++;
         $display("FAIL ign_done: done=%b count=%0d, want 1/4", done, count);
      end
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (done_cnt - d0 != 1 || load_cnt - l0 != 1 || sel !== 2'b00) begin
         errors++;
         $display("FAIL ign_counts: dones=%0d loads=%0d sel=%b, want 1/1/00", done_cnt - d0, load_cnt - l0, sel);
      end
   endtask

   task automatic test_mid_reset();
      int d0;
      checks++;
      if (count !== 4'd4) begin
         errors++;
         $display("FAIL mr_prior: count=%0d, want 4", count);
      end
      par = 8'hFF; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      d0 = done_cnt;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (count !== 4'd0 || sel !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL mr_reset: count=%0d sel=%b busy=%b done=%b, want 0/00/0/0", count, sel, busy, done);
      end
      for (int i = 0; i < 12; i++) tick();
      checks++;
      if (done_cnt != d0 || sel !== 2'b00) begin
         errors++;
         $display("FAIL mr_quiet: dones=%0d sel=%b, want 0/00", done_cnt - d0, sel);
      end
      par = 8'h0F; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      checks++;
      if (done !== 1'b1 || count !== 4'd4) begin
         errors++;
         $display("FAIL mr_restart: done=%b count=%0d, want 1/4", done, count);
      end
      tick();
   endtask

   task automatic test_sweep();
      int n, d0;
      for (int w = 0; w < 256; w++) begin
         d0 = done_cnt;
         par = 8'(w); start = 1'b1;
         tick();
         start = 1'b0;
         n = 0;
         while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
         end
         checks++;
         if (n != 9 || count !== popcnt(8'(w))) begin
            errors++;
            $display("FAIL sweep[%02h]: latency=%0d count=%0d, want 9/%0d", w, n, count, popcnt(8'(w)));
         end
         tick();
         checks++;
         if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL sweep_once[%02h]: dones=%0d, want 1", w, done_cnt - d0);
         end
      end
      checks++;
      if (sel01_cnt != 0) begin
         errors++;
         $display("FAIL sel01: cycles=%0d, want 0", sel01_cnt);
      end
   endtask

   initial begin
      errors = 0; checks = 0;
      done_cnt = 0; load_cnt = 0; sel01_cnt = 0;
      rst = 1'b1; start = 1'b0; par = 8'h00;
      test_reset();
      test_idle();
      test_single_a5();
      test_back_to_back();
      test_ignore_start();
      test_mid_reset();
      test_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
